memoria_lat: RTL and testbench
==============================

MEMORIA_LAT -- requirements
Module: memoria_lat

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, MAR width.
REQ-003 SHALL have parameter MEM_WORDS, default 256, number of storage words (power of two, >= 2).
REQ-004 SHALL have parameter LATENCY, default 1, wait cycles per access, legal range 0..15.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 mem_enable  input  1  request strobe from processor.
REQ-008 mem_op  input  1  1 = write, 0 = read.
REQ-009 MAR  input  ADDR_W  word address.
REQ-010 MBR_out  input  DATA_W  write data, processor to memory.
REQ-011 MBR_in  output  DATA_W  read data, memory to processor.
REQ-012 mem_ready  output  1  one-cycle completion pulse.
REQ-013 mem_err  output  1  one-cycle out-of-range pulse, coincident with mem_ready.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE; IDLE -> DONE directly when LATENCY = 0.
REQ-015 Request SHALL be accepted only at a rising edge with state IDLE and mem_enable = 1; MAR, MBR_out and mem_op are captured at that edge.
REQ-016 Requests with state WAIT or DONE SHALL be ignored, without queueing.
REQ-017 For a request accepted at edge N, mem_ready SHALL be high for exactly the cycle following edge N+1+LATENCY.
REQ-018 Writes SHALL update storage at the edge that raises mem_ready; reads SHALL load MBR_in at that same edge.
REQ-019 MBR_in SHALL hold its value until the next completed read; writes SHALL leave it unchanged.
REQ-020 Wait counter SHALL be 4 bits, load LATENCY-1 on entry to WAIT, decrement each cycle, and leave WAIT when it reaches 0.
REQ-021 Back-to-back throughput SHALL be one access per LATENCY+2 cycles; a request held high through DONE is accepted again in IDLE.
REQ-022 Storage SHALL be an array named mem, indexed in words and not reset, so that benches can backdoor-load it hierarchically.

Reset
REQ-023 Reset SHALL force state IDLE, counter 0, mem_ready 0, mem_err 0 and MBR_in 0.
REQ-024 Reset asserted mid-access SHALL abort the access; a pending write SHALL NOT reach storage.
REQ-025 The first request SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-026 Macro MEMORIA_BOUNDS_CHECK_EN defined: MAR >= MEM_WORDS SHALL suppress the write, return MBR_in = 0 on a read, and pulse mem_err with mem_ready.
REQ-027 Macro undefined: the address SHALL wrap to MAR modulo MEM_WORDS (low log2(MEM_WORDS) bits), and mem_err SHALL be tied to 0.

Structure
REQ-028 Package memoria_pkg SHALL hold the FSM state enumeration, the default DATA_W/ADDR_W/MEM_WORDS/LATENCY constants and the LAT_W = 4 constant.
REQ-029 Sub-module memoria_array SHALL hold the mem storage with a synchronous write port and a registered read port; memoria_lat holds the FSM, counter and range check.

Verification
REQ-030 LATENCY=0: write 32'h10 to MAR 2, then read MAR 2 -> mem_ready 1 cycle after each accept; MBR_in = 16; mem[2] = 16.
REQ-031 LATENCY=3: read of preloaded mem[1] = 4 -> mem_ready exactly 4 cycles after accept; MBR_in = 4.
REQ-032 LATENCY=2: mem_enable held high 12 cycles, reads -> exactly 3 mem_ready pulses, spaced 4 cycles apart.
REQ-033 LATENCY=3: write 32'hFF to MAR 5, reset asserted 1 cycle after accept -> mem[5] unchanged, mem_ready 0, MBR_in 0.
REQ-034 Macro defined, MEM_WORDS=256: write to MAR 300 -> mem_err and mem_ready pulse together, no storage change; macro undefined: the same write updates mem[44].
REQ-035 Preload mem[0..18], run processor scenarios input_data = 10 and 20 with LATENCY = 2 -> Mem[1] = 1/4, Mem[2] = 16/15, output_data = 2/1.

Source files
------------

// File: rtl/memoria_pkg.sv
// memoria_pkg: shared constants and FSM state encoding for the latency memory model.
`default_nettype none

package memoria_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_MEM_WORDS = 256;
    localparam int DEF_LATENCY   = 1;
    localparam int LAT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/memoria_array.sv
// memoria_array: word storage with a synchronous write port and a registered, resettable read port.
`default_nettype none

module memoria_array
    import memoria_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_rzero,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    // Left unreset so testbenches can preload it hierarchically.
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/memoria_lat.sv
// memoria_lat: fixed-latency memory slave (IDLE -> WAIT -> DONE) with one-cycle ready/err pulses.
// Optional macro MEMORIA_BOUNDS_CHECK_EN: out-of-range MAR suppresses writes, reads 0, pulses mem_err.
`default_nettype none

module memoria_lat
    import memoria_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_enable,
    input  logic              mem_op,
    input  logic [ADDR_W-1:0] MAR,
    input  logic [DATA_W-1:0] MBR_out,
    output logic [DATA_W-1:0] MBR_in,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [LAT_W-1:0] c_LAT_M1 = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAT_W-1:0]   r_cnt;
    logic [LAT_W-1:0]   w_cnt_nxt;
    logic               w_accept;
    logic               w_oob;
    logic               w_done;

    logic               r_op;
    logic               r_oob;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_enable) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef MEMORIA_BOUNDS_CHECK_EN
    // MEM_WORDS is a power of two, so any set bit above the index field is out of range.
    assign w_oob = (MAR >> IDX_W) != '0;
`else
    logic w_unused_hi;
    assign w_oob       = 1'b0;
    assign w_unused_hi = ^(MAR >> IDX_W);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op    <= 1'b0;
            r_oob   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= mem_op;
            r_oob   <= w_oob;
            r_idx   <= MAR[IDX_W-1:0];
            r_wdata <= MBR_out;
        end
    end

    // Storage update, read load and ready pulse all happen on the DONE -> IDLE edge.
    assign w_done = (r_state == ST_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_done;
        end
    end

    assign mem_ready = r_ready;

`ifdef MEMORIA_BOUNDS_CHECK_EN
    logic r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_done & r_oob;
        end
    end

    assign mem_err = r_err;
`else
    assign mem_err = 1'b0;
`endif

    memoria_array #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clock),
        .rst     (reset),
        .i_we    (w_done & r_op & ~r_oob),
        .i_re    (w_done & ~r_op),
        .i_rzero (r_oob),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (MBR_in)
    );

endmodule

`default_nettype wire

// File: tb/tb_memoria_lat.sv
// tb_memoria_lat: three memoria_lat instances (LATENCY 0, 3, 2) checked by a response scoreboard.
`default_nettype none

module tb_memoria_lat;

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  en;
    logic [2:0]  op;
    logic [31:0] mar [3];
    logic [31:0] wd  [3];
    logic [31:0] rd  [3];
    logic [2:0]  rdy;
    logic [2:0]  err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        memoria_lat #(
            .DATA_W    (32),
            .ADDR_W    (32),
            .MEM_WORDS (256),
            .LATENCY   ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) u_dut (
            .clock      (clk),
            .reset      (rst[g]),
            .mem_enable (en[g]),
            .mem_op     (op[g]),
            .MAR        (mar[g]),
            .MBR_out    (wd[g]),
            .MBR_in     (rd[g]),
            .mem_ready  (rdy[g]),
            .mem_err    (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request at the next edge; expected response is queued for the monitor.
    task automatic req(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        int acc;
        int lat;
        lat   = lat_of(g);
        en[g] = 1'b1;
        op[g] = w;
        mar[g] = a;
        wd[g] = d;
        acc   = cyc + 1;
        @(posedge clk);
        #1;
        en[g] = 1'b0;
        sb.push_back('{g, acc + 1 + lat, exp_rd, exp_err});
        repeat (lat + 1) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rdy[g]) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ready: dut %0d pulsed at cycle %0d, expected no pulse", g, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_dut", g, mon_e.dut);
                    chk("resp_cycle", cyc, mon_e.cyc);
                    chk("resp_mbr_in", rd[g], mon_e.rd);
                    chk("resp_err", {31'd0, err[g]}, {31'd0, mon_e.err});
                end
            end else if (err[g]) begin
                n_checks++;
                n_errors++;
                $display("FAIL err_without_ready: dut %0d mem_err=1 with mem_ready=0, expected 0", g);
            end
        end
    end

    initial begin
        int a;
        rst = 3'b111;
        en  = 3'b000;
        op  = 3'b000;
        for (int g = 0; g < 3; g++) begin
            mar[g] = '0;
            wd[g]  = '0;
        end
        g_dut[0].u_dut.u_array.mem[44] = 32'h0000_5555;
        g_dut[1].u_dut.u_array.mem[1]  = 32'd4;
        g_dut[1].u_dut.u_array.mem[5]  = 32'h0000_0077;
        g_dut[2].u_dut.u_array.mem[3]  = 32'h0000_0033;

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("reset_mbr_in", rd[g], 32'd0);
            chk("reset_ready", {31'd0, rdy[g]}, 32'd0);
            chk("reset_err", {31'd0, err[g]}, 32'd0);
        end
        rst = 3'b000;

        // LATENCY 0: write then read back, accepted on the first edge after reset.
        req(0, 1'b1, 32'd2, 32'h10, 32'd0, 1'b0);
        req(0, 1'b0, 32'd2, 32'd0, 32'd16, 1'b0);
        chk("lat0_mem2", g_dut[0].u_dut.u_array.mem[2], 32'd16);
`ifdef MEMORIA_BOUNDS_CHECK_EN
        req(0, 1'b1, 32'd300, 32'hAB, 32'd16, 1'b1);
        chk("oob_mem44", g_dut[0].u_dut.u_array.mem[44], 32'h5555);
        req(0, 1'b0, 32'd300, 32'd0, 32'd0, 1'b1);
`else
        req(0, 1'b1, 32'd300, 32'hAB, 32'd16, 1'b0);
        chk("wrap_mem44", g_dut[0].u_dut.u_array.mem[44], 32'hAB);
        req(0, 1'b0, 32'd300, 32'd0, 32'hAB, 1'b0);
`endif

        // LATENCY 3: preloaded read, then a write aborted by reset.
        req(1, 1'b0, 32'd1, 32'd0, 32'd4, 1'b0);
        en[1] = 1'b1; op[1] = 1'b1; mar[1] = 32'd5; wd[1] = 32'hFF;
        @(posedge clk);
        #1;
        en[1] = 1'b0;
        @(posedge clk);
        #1;
        rst[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_mbr_in", rd[1], 32'd0);
        chk("abort_ready", {31'd0, rdy[1]}, 32'd0);
        rst[1] = 1'b0;
        req(1, 1'b0, 32'd1, 32'd0, 32'd4, 1'b0);
        chk("abort_mem5", g_dut[1].u_dut.u_array.mem[5], 32'h77);

        // LATENCY 2: enable held 12 cycles gives three accepts, 4 cycles apart.
        a = cyc;
        en[2] = 1'b1; op[2] = 1'b0; mar[2] = 32'd3;
        sb.push_back('{2, a + 4,  32'h33, 1'b0});
        sb.push_back('{2, a + 8,  32'h33, 1'b0});
        sb.push_back('{2, a + 12, 32'h33, 1'b0});
        repeat (12) @(posedge clk);
        #1;
        en[2] = 1'b0;
        req(2, 1'b1, 32'd7, 32'h99, 32'h33, 1'b0);
        req(2, 1'b0, 32'd7, 32'd0, 32'h99, 1'b0);

        repeat (8) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
